// File: rtl/redmule_stream_addrgen.sv
// Streamer address generator: latches a 3-level addressing job on req_start
// and issues one word address per valid/ready beat, then pulses done.
module redmule_stream_addrgen #(
  parameter int unsigned AW = 32,
  parameter int unsigned LW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic          req_start_i,
  input  logic [AW-1:0] base_addr_i,
  input  logic [LW-1:0] tot_len_i,
  input  logic [LW-1:0] d0_len_i,
  input  logic [AW-1:0] d0_stride_i,
  input  logic [LW-1:0] d1_len_i,
  input  logic [AW-1:0] d1_stride_i,
  input  logic [AW-1:0] d2_stride_i,
  input  logic [1:0]    dim_enable_1h_i,
  output logic          ready_start_o,
  output logic [AW-1:0] addr_o,
  output logic          addr_valid_o,
  input  logic          addr_ready_i,
  output logic          last_o,
  output logic          done_o
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [AW-1:0] base_q;
  logic [LW-1:0] tot_len_q;
  logic [LW-1:0] d0_len_q;
  logic [AW-1:0] d0_stride_q;
  logic [LW-1:0] d1_len_q;
  logic [AW-1:0] d1_stride_q;
  logic [AW-1:0] d2_stride_q;
  logic [1:0]    dim_en_q;

  logic [LW-1:0] beat_cnt_q;
  logic [LW-1:0] d0_cnt_q;
  logic [LW-1:0] d1_cnt_q;
  logic [AW-1:0] d0_off_q;
  logic [AW-1:0] d1_off_q;
  logic [AW-1:0] d2_off_q;

  logic start;
  logic beat;
  logic is_last;
  logic d0_wrap;
  logic d1_wrap;

  assign start   = (state_q == IDLE) && req_start_i;
  assign beat    = (state_q == RUN) && addr_ready_i;
  assign is_last = (state_q == RUN) &&
                   (beat_cnt_q == tot_len_q - LW'(1));
  assign d0_wrap = dim_en_q[0] &&
                   (d0_cnt_q == d0_len_q - LW'(1));
  assign d1_wrap = dim_en_q[1] &&
                   (d1_cnt_q == d1_len_q - LW'(1));

  assign addr_o = base_q + d0_off_q + d1_off_q + d2_off_q;
  assign last_o = is_last;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ready_start_o = 1'b0;
    addr_valid_o  = 1'b0;
    done_o        = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready_start_o = 1'b1;
        if (req_start_i) begin
          state_d = (tot_len_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        addr_valid_o = 1'b1;
        if (addr_ready_i && is_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clear_i) begin
      state_d = IDLE;
    end
  end

  // Zero-length dimensions behave as length 1 so wrap compares stay sane.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      base_q      <= '0;
      tot_len_q   <= '0;
      d0_len_q    <= '0;
      d0_stride_q <= '0;
      d1_len_q    <= '0;
      d1_stride_q <= '0;
      d2_stride_q <= '0;
      dim_en_q    <= '0;
    end else if (!clear_i && start) begin
      base_q      <= base_addr_i;
      tot_len_q   <= tot_len_i;
      d0_len_q    <= (d0_len_i == '0) ? LW'(1) : d0_len_i;
      d0_stride_q <= d0_stride_i;
      d1_len_q    <= (d1_len_i == '0) ? LW'(1) : d1_len_i;
      d1_stride_q <= d1_stride_i;
      d2_stride_q <= d2_stride_i;
      dim_en_q    <= dim_enable_1h_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      beat_cnt_q <= '0;
      d0_cnt_q   <= '0;
      d1_cnt_q   <= '0;
      d0_off_q   <= '0;
      d1_off_q   <= '0;
      d2_off_q   <= '0;
    end else if (clear_i || start) begin
      beat_cnt_q <= '0;
      d0_cnt_q   <= '0;
      d1_cnt_q   <= '0;
      d0_off_q   <= '0;
      d1_off_q   <= '0;
      d2_off_q   <= '0;
    end else if (beat) begin
      beat_cnt_q <= beat_cnt_q + LW'(1);
      if (d0_wrap) begin
        d0_cnt_q <= '0;
        d0_off_q <= '0;
        if (d1_wrap) begin
          d1_cnt_q <= '0;
          d1_off_q <= '0;
          d2_off_q <= d2_off_q + d2_stride_q;
        end else begin
          d1_cnt_q <= d1_cnt_q + LW'(1);
          d1_off_q <= d1_off_q + d1_stride_q;
        end
      end else begin
        d0_cnt_q <= d0_cnt_q + LW'(1);
        d0_off_q <= d0_off_q + d0_stride_q;
      end
    end
  end

endmodule

// File: tb/tb_redmule_stream_addrgen.sv
// Scoreboard bench for redmule_stream_addrgen: directed and random jobs
// compared against a closed-form address model.
module tb_redmule_stream_addrgen;

  localparam int AW = 32;
  localparam int LW = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          clear_i;
  logic          req_start_i;
  logic [AW-1:0] base_addr_i;
  logic [LW-1:0] tot_len_i;
  logic [LW-1:0] d0_len_i;
  logic [AW-1:0] d0_stride_i;
  logic [LW-1:0] d1_len_i;
  logic [AW-1:0] d1_stride_i;
  logic [AW-1:0] d2_stride_i;
  logic [1:0]    dim_enable_1h_i;
  logic          ready_start_o;
  logic [AW-1:0] addr_o;
  logic          addr_valid_o;
  logic          addr_ready_i;
  logic          last_o;
  logic          done_o;

  redmule_stream_addrgen #(.AW(AW), .LW(LW)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .clear_i         (clear_i),
    .req_start_i     (req_start_i),
    .base_addr_i     (base_addr_i),
    .tot_len_i       (tot_len_i),
    .d0_len_i        (d0_len_i),
    .d0_stride_i     (d0_stride_i),
    .d1_len_i        (d1_len_i),
    .d1_stride_i     (d1_stride_i),
    .d2_stride_i     (d2_stride_i),
    .dim_enable_1h_i (dim_enable_1h_i),
    .ready_start_o   (ready_start_o),
    .addr_o          (addr_o),
    .addr_valid_o    (addr_valid_o),
    .addr_ready_i    (addr_ready_i),
    .last_o          (last_o),
    .done_o          (done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] addr;
    logic        last;
  } beat_t;

  beat_t sb[$];
  beat_t exp_b;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int exp_done = 0;
  int rdy_mode = 4;
  int cyc = 0;
  logic        hold_v = 1'b0;
  logic [31:0] hold_a;
  logic        hold_l;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Address of beat i, from the index decomposition of the job.
  function automatic logic [31:0] ref_addr(
    input logic [31:0] b, input int i, input int l0,
    input logic [31:0] s0, input int l1, input logic [31:0] s1,
    input logic [31:0] s2, input logic [1:0] dm);
    int len0, len1, c0, n1, c1, c2;
    len0 = (l0 == 0) ? 1 : l0;
    len1 = (l1 == 0) ? 1 : l1;
    c0 = dm[0] ? i % len0 : i;
    n1 = dm[0] ? i / len0 : 0;
    c1 = dm[1] ? n1 % len1 : n1;
    c2 = dm[1] ? n1 / len1 : 0;
    return b + s0 * 32'(c0) + s1 * 32'(c1) + s2 * 32'(c2);
  endfunction

  // Consumer ready: 0 always, 1 pattern 1,0,0, 2 random, 3 low, 4 manual.
  always @(posedge clk_i) begin
    cyc++;
    #1;
    case (rdy_mode)
      0: addr_ready_i = 1'b1;
      1: addr_ready_i = (cyc % 3 == 1);
      2: addr_ready_i = 1'($urandom % 2);
      3: addr_ready_i = 1'b0;
      default: ;
    endcase
  end

  always @(negedge clk_i) begin
    if (done_o) done_cnt++;
    if (addr_valid_o && hold_v) begin
      chk("stall_addr", addr_o, hold_a);
      chk("stall_last", 32'(last_o), 32'(hold_l));
    end
    hold_v = addr_valid_o && !addr_ready_i;
    hold_a = addr_o;
    hold_l = last_o;
    if (addr_valid_o && addr_ready_i) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got addr %h, required none",
                 addr_o);
      end else begin
        exp_b = sb.pop_front();
        chk("beat_addr", addr_o, exp_b.addr);
        chk("beat_last", 32'(last_o), 32'(exp_b.last));
      end
    end
  end

  task automatic drive_cfg(input logic [31:0] b, input int tot,
    input int l0, input logic [31:0] s0, input int l1,
    input logic [31:0] s1, input logic [31:0] s2,
    input logic [1:0] dm);
    base_addr_i     = b;
    tot_len_i       = LW'(tot);
    d0_len_i        = LW'(l0);
    d0_stride_i     = s0;
    d1_len_i        = LW'(l1);
    d1_stride_i     = s1;
    d2_stride_i     = s2;
    dim_enable_1h_i = dm;
  endtask

  task automatic push_exp(input logic [31:0] b, input int tot,
    input int n, input int l0, input logic [31:0] s0, input int l1,
    input logic [31:0] s1, input logic [31:0] s2,
    input logic [1:0] dm);
    for (int i = 0; i < n; i++) begin
      sb.push_back('{ref_addr(b, i, l0, s0, l1, s1, s2, dm),
                     i == tot - 1});
    end
  endtask

  task automatic run_job(input logic [31:0] b, input int tot,
    input int l0, input logic [31:0] s0, input int l1,
    input logic [31:0] s1, input logic [31:0] s2,
    input logic [1:0] dm, input int mode);
    bit seen;
    push_exp(b, tot, tot, l0, s0, l1, s1, s2, dm);
    exp_done++;
    rdy_mode = mode;
    @(posedge clk_i);
    #1;
    chk("idle_ready_start", 32'(ready_start_o), 32'd1);
    drive_cfg(b, tot, l0, s0, l1, s1, s2, dm);
    req_start_i = 1'b1;
    @(posedge clk_i);
    #1;
    req_start_i = 1'b0;
    drive_cfg($urandom, $urandom_range(1, 50), 3, $urandom,
              2, $urandom, $urandom, 2'($urandom));
    @(negedge clk_i);
    if (tot > 0) chk("first_valid", 32'(addr_valid_o), 32'd1);
    seen = 1'b0;
    for (int n = 0; n < 40 * tot + 20 && !seen; n++) begin
      if (done_o) seen = 1'b1;
      else @(negedge clk_i);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: got no done, required done pulse");
    end else begin
      chk("done_sb_empty", 32'(sb.size()), 32'd0);
      chk("done_ready_start", 32'(ready_start_o), 32'd0);
      chk("done_valid", 32'(addr_valid_o), 32'd0);
      @(negedge clk_i);
      chk("post_done_ready_start", 32'(ready_start_o), 32'd1);
      chk("post_done_done", 32'(done_o), 32'd0);
    end
    sb.delete();
  endtask

  initial begin
    int dc;
    rst_i = 1'b1;
    clear_i = 1'b0;
    req_start_i = 1'b0;
    addr_ready_i = 1'b0;
    drive_cfg(0, 0, 0, 0, 0, 0, 0, 2'b00);
    #2;
    chk("rst_ready_start", 32'(ready_start_o), 32'd1);
    chk("rst_valid", 32'(addr_valid_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_last", 32'(last_o), 32'd0);
    chk("rst_addr", addr_o, 32'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    run_job(32'h2000, 4, 1, 0, 4, 32'h20, 0, 2'b11, 0);
    run_job(32'h1000, 8, 2, 4, 3, 32'h100, 32'h40, 2'b11, 0);
    run_job(32'h1000, 8, 2, 4, 3, 32'h100, 32'h40, 2'b11, 1);
    run_job(32'h3000, 0, 2, 4, 3, 32'h100, 32'h40, 2'b11, 0);
    run_job(32'h4000, 6, 2, 8, 0, 32'h10, 32'h80, 2'b00, 2);

    // Clear after three beats; a start pulse during RUN must be ignored.
    rdy_mode = 4;
    addr_ready_i = 1'b1;
    push_exp(32'h1000, 8, 3, 2, 4, 3, 32'h100, 32'h40, 2'b11);
    @(posedge clk_i);
    #1;
    drive_cfg(32'h1000, 8, 2, 4, 3, 32'h100, 32'h40, 2'b11);
    req_start_i = 1'b1;
    @(posedge clk_i);
    #1 req_start_i = 1'b0;
    @(posedge clk_i);
    #1;
    drive_cfg(32'hdead0000, 5, 1, 1, 1, 1, 1, 2'b00);
    req_start_i = 1'b1;
    @(posedge clk_i);
    #1 req_start_i = 1'b0;
    @(posedge clk_i);
    #1;
    clear_i = 1'b1;
    addr_ready_i = 1'b0;
    dc = done_cnt;
    @(posedge clk_i);
    #1 clear_i = 1'b0;
    @(negedge clk_i);
    chk("clear_valid", 32'(addr_valid_o), 32'd0);
    chk("clear_ready_start", 32'(ready_start_o), 32'd1);
    chk("clear_sb_empty", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk_i);
    chk("clear_no_done", 32'(done_cnt), 32'(dc));
    sb.delete();
    run_job(32'h1000, 8, 2, 4, 3, 32'h100, 32'h40, 2'b11, 2);

    // Asynchronous reset in the middle of a job.
    rdy_mode = 4;
    addr_ready_i = 1'b1;
    push_exp(32'h5000, 10, 2, 3, 8, 2, 32'h10, 32'h100, 2'b11);
    @(posedge clk_i);
    #1;
    drive_cfg(32'h5000, 10, 3, 8, 2, 32'h10, 32'h100, 2'b11);
    req_start_i = 1'b1;
    @(posedge clk_i);
    #1 req_start_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #3 rst_i = 1'b1;
    #1;
    chk("arst_valid", 32'(addr_valid_o), 32'd0);
    chk("arst_done", 32'(done_o), 32'd0);
    chk("arst_ready_start", 32'(ready_start_o), 32'd1);
    chk("arst_last", 32'(last_o), 32'd0);
    chk("arst_addr", addr_o, 32'd0);
    chk("arst_sb_empty", 32'(sb.size()), 32'd0);
    @(negedge clk_i);
    #1 rst_i = 1'b0;
    sb.delete();
    run_job(32'h7000, 5, 2, 4, 2, 32'h40, 32'h400, 2'b11, 0);

    for (int j = 0; j < 25; j++) begin
      run_job($urandom, $urandom_range(0, 30), $urandom_range(0, 4),
              $urandom, $urandom_range(0, 4), $urandom, $urandom,
              2'($urandom), $urandom_range(0, 2));
    end

    repeat (2) @(negedge clk_i);
    chk("done_count", 32'(done_cnt), 32'(exp_done));
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
